// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code parser: strips E0/F0 prefixes, tracks per-button held state, one press pulse per physical keystroke.
// One-cycle registered latency from the completing byte; accepts one byte per cycle with no stall.
module ps2_key_decoder #(
    parameter logic [7:0] CODE1          = 8'h74,
    parameter logic [7:0] CODE2          = 8'h72,
    parameter logic [7:0] CODE3          = 8'h6B,
    parameter bit         REQUIRE_E0     = 1'b1,
    parameter int         TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte_data,
    output logic [2:0] o_press,
    output logic [2:0] o_held,
    output logic       o_error,
    output logic       o_busy
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_press;
    logic [2:0]       r_held;
    logic             r_error;

    logic       w_is_e0;
    logic       w_is_f0;
    logic       w_make;
    logic       w_break;
    logic       w_ext;
    logic       w_seq_err;
    logic       w_timeout;
    logic       w_ext_ok;
    logic [2:0] w_match;

    assign w_is_e0 = (i_byte_data == 8'hE0);
    assign w_is_f0 = (i_byte_data == 8'hF0);

    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_byte_valid && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_make       = 1'b0;
        w_break      = 1'b0;
        w_ext        = 1'b0;
        w_seq_err    = 1'b0;
        if (i_byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_e0)      w_state_next = S_EXT;
                    else if (w_is_f0) w_state_next = S_BRK;
                    else              w_make       = 1'b1;
                end
                S_EXT: begin
                    w_state_next = S_IDLE;
                    w_ext        = 1'b1;
                    if (w_is_f0)      w_state_next = S_EXT_BRK;
                    else if (w_is_e0) w_seq_err    = 1'b1;
                    else              w_make       = 1'b1;
                end
                S_BRK: begin
                    w_state_next = S_IDLE;
                    if (w_is_e0 || w_is_f0) w_seq_err = 1'b1;
                    else                    w_break   = 1'b1;
                end
                S_EXT_BRK: begin
                    w_state_next = S_IDLE;
                    w_ext        = 1'b1;
                    if (w_is_e0 || w_is_f0) w_seq_err = 1'b1;
                    else                    w_break   = 1'b1;
                end
                default: w_state_next = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = S_IDLE;
        end
    end

    assign w_ext_ok   = w_ext || !REQUIRE_E0;
    assign w_match[0] = (i_byte_data == CODE1) && w_ext_ok;
    assign w_match[1] = (i_byte_data == CODE2) && w_ext_ok;
    assign w_match[2] = (i_byte_data == CODE3) && w_ext_ok;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (reset || i_byte_valid || (r_state == S_IDLE) || w_timeout) r_cnt <= '0;
        else                                                           r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_press <= 3'b000;
            r_held  <= 3'b000;
            r_error <= 1'b0;
        end else begin
            r_press <= w_make ? (w_match & ~r_held) : 3'b000;
            if (w_make)       r_held <= r_held | w_match;
            else if (w_break) r_held <= r_held & ~w_match;
            r_error <= w_seq_err || w_timeout;
        end
    end

    assign o_press = r_press;
    assign o_held  = r_held;
    assign o_error = r_error;
    assign o_busy  = (r_state != S_IDLE);

endmodule
